video_pattern_source: RTL and testbench

Synchronous video source producing the pixel stream consumed by the filter chain (`filter_core`-based filters): `d_out`/`dv_out`/`hs_out`/`vs_out` with programmable active size, blanking and test pattern. It is the transmit end of the stream interface whose receive end is `d_in`/`dv_in`/`hs_in`/`vs_in` on every filter. It is used as a bench stimulus source and as an on-chip pattern injector ahead of the filter pipeline.

---
 rtl/video_pattern_pkg.sv | 13 +
 rtl/video_pattern_pix.sv | 34 +++
 rtl/video_pattern_source.sv | 129 ++++++++++++
 tb/tb_video_pattern_source.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pattern_pkg.sv
// video_pattern_pkg: shared FSM state and pattern codes for the video pattern source.
package video_pattern_pkg;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_HBLANK,
        ST_VBLANK
    } state_t;
    localparam logic [1:0] PAT_HRAMP   = 2'd0;
    localparam logic [1:0] PAT_VRAMP   = 2'd1;
    localparam logic [1:0] PAT_CHECKER = 2'd2;
    localparam logic [1:0] PAT_FRAME   = 2'd3;
endpackage

// File: rtl/video_pattern_pix.sv
// video_pattern_pix: registered pixel generator.
// Ports: i_clk/i_rst (sync, active-low), i_valid (active pixel), i_x/i_y (pixel/line index),
// i_fcnt (frame counter), i_pat (pattern code) -> o_pix (0 when not valid).
module video_pattern_pix
    import video_pattern_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic [WIDTH-1:0] i_fcnt,
    input  logic [1:0]       i_pat,
    output logic [WIDTH-1:0] o_pix
);
    logic [WIDTH-1:0] r_pix;
    logic [WIDTH-1:0] w_pix;
    always_comb begin
        w_pix = !i_valid              ? '0 :
                i_pat == PAT_HRAMP    ? i_x :
                i_pat == PAT_VRAMP    ? i_y :
                i_pat == PAT_CHECKER  ? {WIDTH{i_x[3] ^ i_y[3]}} :
                                        i_fcnt;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst)
            r_pix <= '0;
        else
            r_pix <= w_pix;
    end
    assign o_pix = r_pix;
endmodule

// File: rtl/video_pattern_source.sv
// video_pattern_source: programmable video timing + test pattern stream source.
// Ports: i_clk, i_rst (sync, active-low), i_en (run request), i_pix_count/i_line_count (active size),
// i_hblank/i_vblank (blanking), i_pattern_sel -> o_d_out, o_dv_out, o_hs_out, o_vs_out, o_frame_start.
module video_pattern_source
    import video_pattern_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [15:0]      i_pix_count,
    input  logic [15:0]      i_line_count,
    input  logic [15:0]      i_hblank,
    input  logic [15:0]      i_vblank,
    input  logic [1:0]       i_pattern_sel,
    output logic [WIDTH-1:0] o_d_out,
    output logic             o_dv_out,
    output logic             o_hs_out,
    output logic             o_vs_out,
    output logic             o_frame_start
);
    state_t           r_state, w_ns;
    logic [16:0]      r_x, w_nx, w_line;
    logic [15:0]      r_y, w_ny, r_vy, w_nvy;
    logic [15:0]      r_p, r_l, r_h, r_v;
    logic [1:0]       r_pat;
    logic [WIDTH-1:0] r_fcnt;
    logic             r_started;
    logic             r_dv, r_hs, r_vs, r_fs;
    logic             w_start, w_load, w_frame_end;
    assign w_start = i_en && (i_pix_count != 16'd0) && (i_line_count != 16'd0);
    assign w_line  = {1'b0, r_p} + {1'b0, r_h};
    always_comb begin
        w_ns        = r_state;
        w_nx        = r_x + 17'd1;
        w_ny        = r_y;
        w_nvy       = r_vy;
        w_frame_end = 1'b0;
        case (r_state)
            ST_IDLE: w_nx = '0;
            ST_ACTIVE: if (r_x == {1'b0, r_p} - 17'd1) begin
                w_ns = ST_HBLANK;
                w_nx = '0;
            end
            ST_HBLANK: if (r_x == {1'b0, r_h} - 17'd1) begin
                w_nx = '0;
                w_ny = r_y + 16'd1;
                if (r_y + 16'd1 < r_l)
                    w_ns = ST_ACTIVE;
                else if (r_v != 16'd0) begin
                    w_ns  = ST_VBLANK;
                    w_nvy = '0;
                end else
                    w_frame_end = 1'b1;
            end
            ST_VBLANK: if (r_x == w_line - 17'd1) begin
                w_nx        = '0;
                w_nvy       = r_vy + 16'd1;
                w_frame_end = (r_vy + 16'd1 == r_v);
            end
            default: ;
        endcase
        // frame end with no restart falls back to IDLE; a (re)start overrides it
        w_load = (r_state == ST_IDLE || w_frame_end) && w_start;
        if (w_frame_end) begin
            w_ns = ST_IDLE;
            w_ny = '0;
        end
        if (w_load) begin
            w_ns  = ST_ACTIVE;
            w_nx  = '0;
            w_ny  = '0;
            w_nvy = '0;
        end
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state   <= ST_IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_vy      <= '0;
            r_p       <= '0;
            r_l       <= '0;
            r_h       <= '0;
            r_v       <= '0;
            r_pat     <= '0;
            r_fcnt    <= '0;
            r_started <= 1'b0;
            r_dv      <= 1'b0;
            r_hs      <= 1'b0;
            r_vs      <= 1'b0;
            r_fs      <= 1'b0;
        end else begin
            r_state <= w_ns;
            r_x     <= w_nx;
            r_y     <= w_ny;
            r_vy    <= w_nvy;
            if (w_load) begin
                r_p       <= i_pix_count;
                r_l       <= i_line_count;
                r_h       <= (i_hblank == 16'd0) ? 16'd1 : i_hblank;
                r_v       <= i_vblank;
                r_pat     <= i_pattern_sel;
                // the very first frame after reset shows count 0
                r_fcnt    <= r_fcnt + WIDTH'(r_started);
                r_started <= 1'b1;
            end
            r_dv <= (r_state == ST_ACTIVE);
            r_hs <= (r_state == ST_HBLANK) || (r_state == ST_VBLANK && r_x >= {1'b0, r_p});
            r_vs <= (r_state == ST_VBLANK);
            r_fs <= (r_state == ST_ACTIVE) && (r_x == 17'd0) && (r_y == 16'd0);
        end
    end
    video_pattern_pix #(.WIDTH(WIDTH)) u_pix (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_valid(r_state == ST_ACTIVE),
        .i_x    (r_x[WIDTH-1:0]),
        .i_y    (r_y[WIDTH-1:0]),
        .i_fcnt (r_fcnt),
        .i_pat  (r_pat),
        .o_pix  (o_d_out)
    );
    assign o_dv_out      = r_dv;
    assign o_hs_out      = r_hs;
    assign o_vs_out      = r_vs;
    assign o_frame_start = r_fs;
endmodule

// File: tb/tb_video_pattern_source.sv
// tb_video_pattern_source: self-checking bench with a frame-arithmetic reference model.
module tb_video_pattern_source;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [15:0] pix_count = '0, line_count = '0, hblank = '0, vblank = '0;
    logic [1:0]  pattern_sel = '0;
    logic [7:0]  d_out;
    logic        dv_out, hs_out, vs_out, frame_start;
    logic [11:0] obs, exp_vec;
    int n_cmp = 0, n_err = 0;
    int m_p, m_l, m_h, m_v, m_pat, m_t, m_fc;
    bit m_run = 0, m_started = 0;
    video_pattern_source #(.WIDTH(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_pix_count(pix_count), .i_line_count(line_count),
        .i_hblank(hblank), .i_vblank(vblank), .i_pattern_sel(pattern_sel), .o_d_out(d_out),
        .o_dv_out(dv_out), .o_hs_out(hs_out), .o_vs_out(vs_out), .o_frame_start(frame_start)
    );
    always #5 clk = ~clk;
    assign obs = {dv_out, hs_out, vs_out, frame_start, d_out};
    // Reference: each frame is (L+V) lines of (P+H) cycles, position derived by division.
    always @(posedge clk) begin
        int lp, ln, c, pv;
        bit start;
        if (!rst) begin
            exp_vec = '0; m_run = 0; m_t = 0; m_fc = 0; m_started = 0;
        end else begin
            exp_vec = '0;
            if (m_run) begin
                lp = m_p + m_h; ln = m_t / lp; c = m_t % lp;
                if (ln < m_l) begin
                    if (c < m_p) begin
                        pv = m_pat == 0 ? c % 256 : m_pat == 1 ? ln % 256 :
                             m_pat == 2 ? (((c / 8) % 2 != (ln / 8) % 2) ? 255 : 0) : m_fc;
                        exp_vec = {1'b1, 1'b0, 1'b0, m_t == 0, 8'(pv)};
                    end else exp_vec = {4'b0100, 8'h00};
                end else exp_vec = {1'b0, c >= m_p, 1'b1, 1'b0, 8'h00};
            end
            start = en && pix_count != 0 && line_count != 0;
            if (m_run) begin
                m_t++;
                if (m_t == (m_l + m_v) * (m_p + m_h)) m_run = 0;
            end
            if (!m_run && start) begin
                m_p = pix_count; m_l = line_count; m_h = hblank == 0 ? 1 : int'(hblank);
                m_v = vblank; m_pat = pattern_sel; m_t = 0; m_run = 1;
                if (m_started) m_fc = (m_fc + 1) % 256;
                m_started = 1;
            end
        end
    end
    task automatic do_reset();
        @(negedge clk); rst = 0; en = 0;
        @(negedge clk); rst = 1;
    endtask
    task automatic set_cfg(int p, int l, int h, int v, int pat);
        pix_count = 16'(p); line_count = 16'(l); hblank = 16'(h); vblank = 16'(v); pattern_sel = 2'(pat);
    endtask
    task automatic test_reset();
        @(negedge clk); rst = 0; en = 1; set_cfg(4, 2, 2, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== 12'h000 || exp_vec !== 12'h000) begin
                n_err++; $display("FAIL reset: got %h want 000", obs);
            end
        end
        en = 0; rst = 1;
    endtask
    task automatic test_basic();
        int fs_last = -1, fs_n = 0, dv_n = 0, hs_n = 0, vs_n = 0;
        logic [7:0] seq [8];
        do_reset();
        set_cfg(4, 2, 2, 1, 0); en = 1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_vec) begin n_err++; $display("FAIL basic cyc %0d: got %h want %h", cyc, obs, exp_vec); end
            if (frame_start) begin
                fs_n++;
                if (fs_last >= 0) begin
                    n_cmp++;
                    if (cyc - fs_last != 18) begin n_err++; $display("FAIL basic period: got %0d want 18", cyc - fs_last); end
                end
                fs_last = cyc;
            end
            if (cyc >= 1 && cyc <= 18) begin
                if (dv_out && dv_n < 8) seq[dv_n] = d_out;
                dv_n += int'(dv_out); hs_n += int'(hs_out); vs_n += int'(vs_out);
            end
        end
        n_cmp += 4;
        if (fs_n != 4) begin n_err++; $display("FAIL basic fs count: got %0d want 4", fs_n); end
        if (dv_n != 8) begin n_err++; $display("FAIL basic dv count: got %0d want 8", dv_n); end
        if (hs_n != 6) begin n_err++; $display("FAIL basic hs count: got %0d want 6", hs_n); end
        if (vs_n != 6) begin n_err++; $display("FAIL basic vs count: got %0d want 6", vs_n); end
        for (int i = 0; i < 8 && i < dv_n; i++) begin
            n_cmp++;
            if (seq[i] !== 8'(i % 4)) begin n_err++; $display("FAIL basic ramp %0d: got %0d want %0d", i, seq[i], i % 4); end
        end
    endtask
    task automatic test_checker();
        int fs_last = -1, k = 0;
        logic [7:0] pix [256];
        do_reset();
        set_cfg(16, 16, 1, 0, 2); en = 1;
        for (int cyc = 0; cyc < 560; cyc++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_vec) begin n_err++; $display("FAIL checker cyc %0d: got %h want %h", cyc, obs, exp_vec); end
            if (frame_start) begin
                if (fs_last >= 0) begin
                    n_cmp++;
                    if (cyc - fs_last != 272) begin n_err++; $display("FAIL checker period: got %0d want 272", cyc - fs_last); end
                end
                fs_last = cyc;
            end
            if (dv_out && cyc <= 272 && k < 256) begin pix[k] = d_out; k++; end
        end
        n_cmp += 4;
        if (k != 256) begin n_err++; $display("FAIL checker dv count: got %0d want 256", k); end
        if (pix[8] !== 8'hFF) begin n_err++; $display("FAIL checker (8,0): got %h want ff", pix[8]); end
        if (pix[136] !== 8'h00) begin n_err++; $display("FAIL checker (8,8): got %h want 00", pix[136]); end
        if (pix[128] !== 8'hFF) begin n_err++; $display("FAIL checker (0,8): got %h want ff", pix[128]); end
    endtask
    task automatic test_frame_count();
        int k = 0;
        logic [7:0] vals [260];
        do_reset();
        set_cfg(1, 1, 1, 0, 3); en = 1;
        for (int cyc = 0; cyc < 522; cyc++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_vec) begin n_err++; $display("FAIL fcount cyc %0d: got %h want %h", cyc, obs, exp_vec); end
            if (dv_out && k < 260) begin vals[k] = d_out; k++; end
        end
        n_cmp++;
        if (k != 260) begin n_err++; $display("FAIL fcount frames: got %0d want 260", k); end
        for (int i = 0; i < 260 && i < k; i++) begin
            if (i < 3 || i == 255 || i == 256 || i == 257) begin
                n_cmp++;
                if (vals[i] !== 8'(i % 256)) begin n_err++; $display("FAIL fcount frame %0d: got %0d want %0d", i, vals[i], i % 256); end
            end
        end
    endtask
    task automatic test_en_drop();
        int dv_n = 0;
        do_reset();
        set_cfg(4, 4, 1, 0, 0); en = 1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (cyc == 6) en = 0;
            n_cmp++;
            if (obs !== exp_vec) begin n_err++; $display("FAIL endrop cyc %0d: got %h want %h", cyc, obs, exp_vec); end
            dv_n += int'(dv_out);
            if (cyc >= 30) begin
                n_cmp++;
                if (obs !== 12'h000) begin n_err++; $display("FAIL endrop idle: got %h want 000", obs); end
            end
        end
        n_cmp++;
        if (dv_n != 16) begin n_err++; $display("FAIL endrop dv count: got %0d want 16", dv_n); end
        en = 1;
        @(negedge clk);
        n_cmp++;
        if (dv_out !== 1'b0) begin n_err++; $display("FAIL endrop restart early: got %b want 0", dv_out); end
        @(negedge clk);
        n_cmp++;
        if ({dv_out, frame_start, d_out} !== 10'h300) begin n_err++; $display("FAIL endrop restart: got %h want 300", {dv_out, frame_start, d_out}); end
    endtask
    task automatic test_mid_reset();
        do_reset();
        set_cfg(8, 2, 2, 0, 0); en = 1;
        repeat (4) @(negedge clk);
        rst = 0;
        @(negedge clk);
        n_cmp++;
        if (obs !== 12'h000) begin n_err++; $display("FAIL midrst clear: got %h want 000", obs); end
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (obs !== 12'h900) begin n_err++; $display("FAIL midrst restart: got %h want 900", obs); end
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_vec) begin n_err++; $display("FAIL midrst cyc %0d: got %h want %h", cyc, obs, exp_vec); end
        end
    endtask
    task automatic test_zero();
        int fs_last = -1;
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            if (pass == 0) set_cfg(0, 3, 2, 1, 0); else set_cfg(4, 0, 2, 1, 0);
            en = 1;
            for (int cyc = 0; cyc < 40; cyc++) begin
                @(negedge clk);
                n_cmp++;
                if (obs !== 12'h000) begin n_err++; $display("FAIL zero pass %0d: got %h want 000", pass, obs); end
            end
        end
        set_cfg(4, 1, 0, 0, 0);
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_vec) begin n_err++; $display("FAIL hb0 cyc %0d: got %h want %h", cyc, obs, exp_vec); end
            if (frame_start) begin
                if (fs_last >= 0) begin
                    n_cmp++;
                    if (cyc - fs_last != 5) begin n_err++; $display("FAIL hb0 period: got %0d want 5", cyc - fs_last); end
                end
                fs_last = cyc;
            end
        end
    endtask
    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            @(negedge clk);
            set_cfg($urandom_range(8, 0), $urandom_range(4, 0), $urandom_range(3, 0), $urandom_range(2, 0), $urandom_range(3, 0));
            en = 1;
            for (int cyc = 0; cyc < 400; cyc++) begin
                @(negedge clk);
                n_cmp++;
                if (obs !== exp_vec) begin n_err++; $display("FAIL random it %0d cyc %0d: got %h want %h", it, cyc, obs, exp_vec); end
                if ($urandom_range(19, 0) == 0)
                    set_cfg($urandom_range(8, 1), $urandom_range(4, 1), $urandom_range(3, 0), $urandom_range(2, 0), $urandom_range(3, 0));
                if ($urandom_range(29, 0) == 0) en = ~en;
                rst = ($urandom_range(199, 0) != 0);
            end
            rst = 1;
        end
    endtask
    initial begin
        test_reset();
        test_basic();
        test_checker();
        test_frame_count();
        test_en_drop();
        test_mid_reset();
        test_zero();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
